rom_read_arbiter: RTL and testbench

Sequencer and two-port arbiter for the 256 x 8 combinational ROM (inputs `address`, `ce`, `read_en`; output `data`). Two requesters each issue a start address and burst length. The block grants them round-robin, drives the ROM control lines from registers, and returns registered read data tagged with the requester id. It sits between the ROM and its consumers, which never drive the ROM directly.

---
 rtl/rom_read_arbiter_if.sv | 33 +++
 rtl/rom_read_arbiter.sv | 115 +++++++++++
 tb/tb_rom_read_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_read_arbiter_if.sv
// Bundle of requester, read-return and ROM control signals for rom_read_arbiter.
// The slave modport is the arbiter itself; master is the surrounding environment.
interface rom_read_arbiter_if;
   logic       req0;
   logic       req1;
   logic [7:0] addr0;
   logic [7:0] addr1;
   logic [1:0] len0;
   logic [1:0] len1;
   logic       gnt0;
   logic       gnt1;
   logic       rvalid;
   logic [7:0] rdata;
   logic       rid;
   logic       rlast;
   logic       busy;
   logic [7:0] rom_address;
   logic       rom_ce;
   logic       rom_read_en;
   logic [7:0] rom_data;

   modport slave (
      input  req0, req1, addr0, addr1, len0, len1, rom_data,
      output gnt0, gnt1, rvalid, rdata, rid, rlast, busy,
             rom_address, rom_ce, rom_read_en
   );

   modport master (
      output req0, req1, addr0, addr1, len0, len1, rom_data,
      input  gnt0, gnt1, rvalid, rdata, rid, rlast, busy,
             rom_address, rom_ce, rom_read_en
   );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin two-port burst sequencer in front of a 256x8 combinational ROM.
// All outputs come straight from registers; read data is tagged with its owner.
module rom_read_arbiter (
   input logic                clk,
   input logic                reset_n,
   rom_read_arbiter_if.slave  bus
);

   typedef enum logic {IDLE, READ} state_t;

   state_t     state_q, state_d;
   logic [7:0] addr_q, addr_d;
   logic [1:0] cnt_q, cnt_d;
   logic       owner_q, owner_d;
   logic       lastOwner_q, lastOwner_d;
   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;
   logic       rvalid_q, rvalid_d;
   logic       rlast_q, rlast_d;
   logic       rid_q, rid_d;
   logic       ce_q, ce_d;
   logic [7:0] rdata_q, rdata_d;

   logic anyReq;
   logic pick1;
   logic canGrant;

   assign anyReq   = bus.req0 | bus.req1;
   assign pick1    = bus.req1 & (~bus.req0 | ~lastOwner_q);
   // The edge that retires the last byte doubles as the IDLE decision point,
   // so the next grant lands in the rlast cycle and the byte stream has no gap.
   assign canGrant = (state_q == IDLE) || (cnt_q == 2'd0);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      lastOwner_d = lastOwner_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      rvalid_d    = 1'b0;
      rlast_d     = 1'b0;
      rid_d       = rid_q;
      rdata_d     = rdata_q;
      ce_d        = ce_q;

      if (state_q == READ) begin
         rdata_d  = bus.rom_data;
         rvalid_d = 1'b1;
         rid_d    = owner_q;
         rlast_d  = (cnt_q == 2'd0);
         if (cnt_q != 2'd0) begin
            cnt_d  = cnt_q - 2'd1;
            addr_d = addr_q + 8'd1;
         end else begin
            ce_d    = 1'b0;
            state_d = IDLE;
         end
      end

      if (canGrant && anyReq) begin
         gnt0_d      = ~pick1;
         gnt1_d      = pick1;
         addr_d      = pick1 ? bus.addr1 : bus.addr0;
         cnt_d       = pick1 ? bus.len1 : bus.len0;
         owner_d     = pick1;
         lastOwner_d = pick1;
         ce_d        = 1'b1;
         state_d     = READ;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         addr_q      <= 8'd0;
         cnt_q       <= 2'd0;
         owner_q     <= 1'b0;
         lastOwner_q <= 1'b1;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         rvalid_q    <= 1'b0;
         rlast_q     <= 1'b0;
         rid_q       <= 1'b0;
         rdata_q     <= 8'd0;
         ce_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         lastOwner_q <= lastOwner_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         rvalid_q    <= rvalid_d;
         rlast_q     <= rlast_d;
         rid_q       <= rid_d;
         rdata_q     <= rdata_d;
         ce_q        <= ce_d;
      end
   end

   assign bus.gnt0        = gnt0_q;
   assign bus.gnt1        = gnt1_q;
   assign bus.rvalid      = rvalid_q;
   assign bus.rlast       = rlast_q;
   assign bus.rid         = rid_q;
   assign bus.rdata       = rdata_q;
   assign bus.busy        = (state_q == READ);
   assign bus.rom_address = addr_q;
   assign bus.rom_ce      = ce_q;
   assign bus.rom_read_en = ce_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: directed scenarios plus random traffic, checked
// against a schedule-based model of grants and returned bytes.
module tb_rom_read_arbiter;

   logic clk = 1'b0;
   logic resetN;

   rom_read_arbiter_if bus();

   rom_read_arbiter dut (
      .clk     (clk),
      .reset_n (resetN),
      .bus     (bus.slave)
   );

   assign bus.rom_data = bus.rom_address ^ 8'h5A;

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       id;
      logic       last;
   } beat_t;

   beat_t      beatQ[$];
   int         cyc;
   int         freeAt;
   int         busyEnd;
   int         ceStart;
   logic [7:0] ceBase;
   logic       lastOwnerM;
   logic       expGnt0, expGnt1, expRvalid, expRlast, expRid, expBusy;
   logic [7:0] expRdata, expRomAddr;
   logic       hold0, hold1;

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic checkByte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%02h expected=0x%02h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic modelReset();
      beatQ.delete();
      freeAt     = 0;
      busyEnd    = -1;
      lastOwnerM = 1'b1;
      expGnt0    = 1'b0;
      expGnt1    = 1'b0;
      expRvalid  = 1'b0;
      expRlast   = 1'b0;
      expRid     = 1'b0;
      expRdata   = 8'h00;
      expBusy    = 1'b0;
      expRomAddr = 8'h00;
   endtask

   // Grants may happen once the previous burst's last byte is being returned.
   task automatic modelStep(input logic r0, input logic r1,
                            input logic [7:0] a0, input logic [7:0] a1,
                            input logic [1:0] l0, input logic [1:0] l1);
      logic       w;
      logic [7:0] a;
      int         l;
      beat_t      b;
      expGnt0 = 1'b0;
      expGnt1 = 1'b0;
      if (cyc >= freeAt && (r0 || r1)) begin
         w = (r0 && r1) ? ~lastOwnerM : r1;
         a = w ? a1 : a0;
         l = w ? int'(l1) : int'(l0);
         expGnt0 = ~w;
         expGnt1 = w;
         for (int i = 0; i <= l; i++) begin
            b.cyc  = cyc + 1 + i;
            b.data = (a + 8'(i)) ^ 8'h5A;
            b.id   = w;
            b.last = (i == l);
            beatQ.push_back(b);
         end
         freeAt     = cyc + 1 + l;
         busyEnd    = cyc + l;
         ceStart    = cyc;
         ceBase     = a;
         lastOwnerM = w;
      end
      expRvalid = 1'b0;
      expRlast  = 1'b0;
      if (beatQ.size() > 0 && beatQ[0].cyc == cyc) begin
         b = beatQ.pop_front();
         expRvalid = 1'b1;
         expRlast  = b.last;
         expRid    = b.id;
         expRdata  = b.data;
      end
      expBusy = (cyc <= busyEnd);
      if (expBusy) expRomAddr = ceBase + 8'(cyc - ceStart);
   endtask

   task automatic applyStimulus();
      logic       sR0, sR1, sRst;
      logic [7:0] sA0, sA1;
      logic [1:0] sL0, sL1;
      sR0 = bus.req0;  sR1 = bus.req1;
      sA0 = bus.addr0; sA1 = bus.addr1;
      sL0 = bus.len0;  sL1 = bus.len1;
      sRst = resetN;
      @(posedge clk);
      cyc++;
      if (!sRst) modelReset();
      else modelStep(sR0, sR1, sA0, sA1, sL0, sL1);
      #1;
      if (expGnt0 && !hold0) bus.req0 = 1'b0;
      if (expGnt1 && !hold1) bus.req1 = 1'b0;
   endtask

   task automatic checkOutput();
      checkBit("gnt0", bus.gnt0, expGnt0);
      checkBit("gnt1", bus.gnt1, expGnt1);
      checkBit("rvalid", bus.rvalid, expRvalid);
      checkBit("rlast", bus.rlast, expRlast);
      checkBit("busy", bus.busy, expBusy);
      checkBit("rom_ce", bus.rom_ce, expBusy);
      checkBit("rom_read_en", bus.rom_read_en, expBusy);
      if (expRvalid) begin
         checkByte("rdata", bus.rdata, expRdata);
         checkBit("rid", bus.rid, expRid);
      end
      if (expBusy) checkByte("rom_address", bus.rom_address, expRomAddr);
   endtask

   task automatic checkAllZero(input string tag);
      checkBit({tag, "_gnt0"}, bus.gnt0, 1'b0);
      checkBit({tag, "_gnt1"}, bus.gnt1, 1'b0);
      checkBit({tag, "_rvalid"}, bus.rvalid, 1'b0);
      checkBit({tag, "_rlast"}, bus.rlast, 1'b0);
      checkBit({tag, "_rid"}, bus.rid, 1'b0);
      checkBit({tag, "_busy"}, bus.busy, 1'b0);
      checkBit({tag, "_rom_ce"}, bus.rom_ce, 1'b0);
      checkBit({tag, "_rom_read_en"}, bus.rom_read_en, 1'b0);
      checkByte({tag, "_rdata"}, bus.rdata, 8'h00);
      checkByte({tag, "_rom_address"}, bus.rom_address, 8'h00);
   endtask

   initial begin
      logic [7:0] wrapData [4];
      wrapData[0] = 8'hA4; wrapData[1] = 8'hA5; wrapData[2] = 8'h5A; wrapData[3] = 8'h5B;

      cyc = 0;
      hold0 = 1'b0; hold1 = 1'b0;
      resetN = 1'b0;
      bus.req0 = 1'b0;   bus.req1 = 1'b0;
      bus.addr0 = 8'h00; bus.addr1 = 8'h00;
      bus.len0 = 2'd0;   bus.len1 = 2'd0;
      modelReset();
      #1;
      checkAllZero("reset");
      applyStimulus();
      checkOutput();
      resetN = 1'b1;
      applyStimulus();
      checkOutput();

      // Single read
      bus.req0 = 1'b1; bus.addr0 = 8'h10; bus.len0 = 2'd0;
      applyStimulus();
      checkOutput();
      checkBit("single_gnt0", bus.gnt0, 1'b1);
      applyStimulus();
      checkOutput();
      checkByte("single_rdata", bus.rdata, 8'h4A);
      checkBit("single_rlast", bus.rlast, 1'b1);
      checkBit("single_rid", bus.rid, 1'b0);
      for (int i = 0; i < 2; i++) begin applyStimulus(); checkOutput(); end

      // Burst that wraps 0xFF -> 0x00
      bus.req1 = 1'b1; bus.addr1 = 8'hFE; bus.len1 = 2'd3;
      applyStimulus();
      checkOutput();
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkOutput();
         checkByte("wrap_rdata", bus.rdata, wrapData[i]);
         checkBit("wrap_rid", bus.rid, 1'b1);
         checkBit("wrap_rlast", bus.rlast, i == 3);
      end
      for (int i = 0; i < 2; i++) begin applyStimulus(); checkOutput(); end

      // Tie from reset, both requesters re-asserting
      resetN = 1'b0;
      #1;
      modelReset();
      checkAllZero("tie_reset");
      bus.req0 = 1'b1; bus.req1 = 1'b1; bus.len0 = 2'd0; bus.len1 = 2'd0;
      bus.addr0 = 8'h20; bus.addr1 = 8'h21;
      hold0 = 1'b1; hold1 = 1'b1;
      applyStimulus();
      checkOutput();
      resetN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkOutput();
         checkBit("tie_gnt0", bus.gnt0, (i % 2) == 0);
         checkBit("tie_gnt1", bus.gnt1, (i % 2) == 1);
         if (i > 0) checkBit("tie_rlast_with_gnt", bus.rlast, 1'b1);
      end
      hold0 = 1'b0; hold1 = 1'b0;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      for (int i = 0; i < 3; i++) begin applyStimulus(); checkOutput(); end

      // Back-to-back bursts from requester 0
      bus.req0 = 1'b1; bus.addr0 = 8'h30; bus.len0 = 2'd1;
      hold0 = 1'b1;
      for (int i = 0; i < 11; i++) begin
         if (i == 6) hold0 = 1'b0;
         applyStimulus();
         checkOutput();
         if (i >= 1 && i <= 8) checkBit("b2b_rvalid", bus.rvalid, 1'b1);
      end

      // Reset in the middle of a burst
      bus.req0 = 1'b1; bus.addr0 = 8'h80; bus.len0 = 2'd3;
      for (int i = 0; i < 3; i++) begin applyStimulus(); checkOutput(); end
      checkBit("midrst_second_rvalid", bus.rvalid, 1'b1);
      resetN = 1'b0;
      #1;
      modelReset();
      checkAllZero("midrst");
      bus.req0 = 1'b1; bus.req1 = 1'b1; bus.len0 = 2'd0; bus.len1 = 2'd0;
      applyStimulus();
      checkOutput();
      resetN = 1'b1;
      applyStimulus();
      checkOutput();
      checkBit("midrst_tie_gnt0", bus.gnt0, 1'b1);
      for (int i = 0; i < 3; i++) begin applyStimulus(); checkOutput(); end

      // Random traffic with addresses and lengths churning every cycle
      hold0 = 1'b1; hold1 = 1'b1;
      for (int i = 0; i < 400; i++) begin
         bus.addr0 = 8'($urandom); bus.addr1 = 8'($urandom);
         bus.len0  = 2'($urandom); bus.len1  = 2'($urandom);
         applyStimulus();
         checkOutput();
         if (expGnt0) bus.req0 = ($urandom_range(0, 3) == 0);
         else if (!bus.req0) bus.req0 = ($urandom_range(0, 2) == 0);
         if (expGnt1) bus.req1 = ($urandom_range(0, 3) == 0);
         else if (!bus.req1) bus.req1 = ($urandom_range(0, 2) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
